// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 line, with a
// registered falling-edge pulse on the filtered level.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fall_q, fall_d;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, folds E0/F0 prefixes
// into key events and queues them in a show-ahead FIFO.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] evt_code,
    output logic       evt_extended,
    output logic       evt_release,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       err_strb,
    output logic [1:0] err_code,
    output logic       overflow_strb
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam logic [AddrW:0] DepthVal = (AddrW + 1)'(FIFO_DEPTH);

    logic clk_fall, data_filt;
    logic clk_level_unused, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (ps2_clk),
        .level_o(clk_level_unused),
        .fall_o (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (ps2_data),
        .level_o(data_filt),
        .fall_o (data_fall_unused)
    );

    // ---------------- deframer ----------------
    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             byte_done_q, byte_done_d;
    logic             err_strb_q, err_strb_d;
    logic [1:0]       err_code_q, err_code_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        byte_done_d = 1'b0;
        err_strb_d  = 1'b0;
        err_code_d  = err_code_q;

        // Counts cycles since the last fall, so the abort lands exactly
        // TIMEOUT_CYCLES after it.
        if (state_q == StIdle) begin
            idle_cnt_d = '0;
        end else if (clk_fall) begin
            idle_cnt_d = IdleW'(1);
        end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (clk_fall && !data_filt) begin
                    state_d    = StData;
                    bit_cnt_d  = '0;
                    idle_cnt_d = IdleW'(1);
                end
            end
            StData: begin
                if (clk_fall) begin
                    shift_d   = {data_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (clk_fall) begin
                    parity_d = data_filt;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (clk_fall) begin
                    state_d = StIdle;
                    if (!(^{shift_q, parity_q})) begin
                        err_strb_d = 1'b1;
                        err_code_d = ERR_PARITY;
                    end else if (!data_filt) begin
                        err_strb_d = 1'b1;
                        err_code_d = ERR_STOP;
                    end else begin
                        byte_done_d = 1'b1;
                    end
                end
            end
        endcase

        if (state_q != StIdle && !clk_fall && idle_cnt_q == IdleLast) begin
            state_d    = StIdle;
            idle_cnt_d = '0;
            err_strb_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            idle_cnt_q  <= '0;
            byte_done_q <= 1'b0;
            err_strb_q  <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            idle_cnt_q  <= idle_cnt_d;
            byte_done_q <= byte_done_d;
            err_strb_q  <= err_strb_d;
            err_code_q  <= err_code_d;
        end
    end

    // ---------------- prefix decoder ----------------
    logic     ext_pend_q, ext_pend_d;
    logic     brk_pend_q, brk_pend_d;
    logic     push_q, push_d;
    ps2_evt_t push_evt_q, push_evt_d;

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push_d     = 1'b0;
        push_evt_d = push_evt_q;
        if (err_strb_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_done_q) begin
            if (shift_q == PS2_PREFIX_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
                brk_pend_d = 1'b1;
            end else begin
                push_d     = 1'b1;
                push_evt_d = '{ext: ext_pend_q, rel: brk_pend_q, code: shift_q};
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            push_q     <= 1'b0;
            push_evt_q <= '0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            push_q     <= push_d;
            push_evt_q <= push_evt_d;
        end
    end

    // ---------------- event FIFO ----------------
    ps2_evt_t       mem_q [FIFO_DEPTH];
    logic [AddrW:0] wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full, pop, push_ok;
    logic           overflow_q;
    ps2_evt_t       head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == DepthVal);
    assign pop        = !fifo_empty && evt_ready;
    // A pop frees the slot in the same edge, so a push while full still lands.
    assign push_ok    = push_q && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AddrW-1:0]] <= push_evt_q;
                wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
            overflow_q <= push_q && !push_ok;
        end
    end

    assign head          = mem_q[rd_ptr_q[AddrW-1:0]];
    assign evt_code      = head.code;
    assign evt_extended  = head.ext;
    assign evt_release   = head.rel;
    assign evt_valid     = !fifo_empty;
    assign err_strb      = err_strb_q;
    assign err_code      = err_code_q;
    assign overflow_strb = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frames, prefixes, errors, timeout,
// FIFO overflow and mid-frame reset.
module tb_ps2_scancode_receiver;

    localparam int unsigned FILT    = 8;
    localparam int unsigned TIMEOUT = 50000;
    localparam int unsigned DEPTH   = 4;
    localparam int          HALF    = 20;
    localparam int          GAP     = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data;
    logic [7:0] evt_code;
    logic       evt_extended, evt_release, evt_valid, evt_ready;
    logic       err_strb, overflow_strb;
    logic [1:0] err_code;

    int n_vec  = 0;
    int n_fail = 0;
    int n_err  = 0;
    int n_ovf  = 0;
    int base;
    logic [9:0] ev_q[$];

    always #10 clk = ~clk;

    ps2_scancode_receiver #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .evt_code     (evt_code),
        .evt_extended (evt_extended),
        .evt_release  (evt_release),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .err_strb     (err_strb),
        .err_code     (err_code),
        .overflow_strb(overflow_strb)
    );

    // Inputs change at posedge+2; this monitor samples at negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (err_strb) n_err++;
            if (overflow_strb) n_ovf++;
            if (evt_valid && evt_ready) ev_q.push_back({evt_extended, evt_release, evt_code});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                             input logic bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Leaves ps2_clk low after the last bit's falling edge.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (i < n - 1) begin
                wait_cyc(HALF);
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic end_frame();
        wait_cyc(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bits(mk_frame(d, bad_par, bad_stop), 11);
        end_frame();
    endtask

    task automatic expect_event(input string tag, input logic [9:0] exp);
        if (ev_q.size() == 0) check_eq(tag, 32'hDEAD, {22'd0, exp});
        else check_eq(tag, {22'd0, ev_q.pop_front()}, {22'd0, exp});
    endtask

    initial begin
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        evt_ready = 1'b1;
        wait_cyc(3);
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_code", evt_code, 0);
        check_eq("rst_ext", evt_extended, 0);
        check_eq("rst_rel", evt_release, 0);
        check_eq("rst_err_strb", err_strb, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_ovf", overflow_strb, 0);
        rst = 1'b0;
        wait_cyc(5);

        // Plain make code, with write latency after the stop-bit edge.
        base = n_err;
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
        wait_cyc(12);
        check_eq("lat_valid_early", evt_valid, 0);
        wait_cyc(1);
        check_eq("lat_valid", evt_valid, 1);
        check_eq("lat_code", evt_code, 8'h1C);
        check_eq("lat_ext", evt_extended, 0);
        check_eq("lat_rel", evt_release, 0);
        end_frame();
        expect_event("ev_1c", {2'b00, 8'h1C});
        check_eq("no_err_1c", n_err - base, 0);

        frame(8'hF0, 1'b0, 1'b0);
        check_eq("prefix_no_evt", ev_q.size(), 0);
        frame(8'h21, 1'b0, 1'b0);
        expect_event("ev_brk_21", {2'b01, 8'h21});
        frame(8'hE0, 1'b0, 1'b0);
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h74, 1'b0, 1'b0);
        expect_event("ev_ext_brk_74", {2'b11, 8'h74});
        check_eq("prefix_only_one", ev_q.size(), 0);

        // Bad parity, with strobe timing.
        base = n_err;
        send_bits(mk_frame(8'h29, 1'b1, 1'b0), 11);
        wait_cyc(10);
        check_eq("perr_strb_early", err_strb, 0);
        wait_cyc(1);
        check_eq("perr_strb", err_strb, 1);
        check_eq("perr_code", err_code, 2'b01);
        end_frame();
        check_eq("perr_count", n_err - base, 1);
        check_eq("perr_no_evt", ev_q.size(), 0);
        frame(8'h32, 1'b0, 1'b0);
        expect_event("ev_32", {2'b00, 8'h32});

        // Bad stop bit.
        base = n_err;
        frame(8'h45, 1'b0, 1'b1);
        check_eq("serr_count", n_err - base, 1);
        check_eq("serr_code", err_code, 2'b10);
        check_eq("serr_no_evt", ev_q.size(), 0);

        // Error discards a pending prefix.
        frame(8'hE0, 1'b0, 1'b0);
        frame(8'h29, 1'b1, 1'b0);
        frame(8'h1C, 1'b0, 1'b0);
        expect_event("err_clears_ext", {2'b00, 8'h1C});

        // Short low glitch on ps2_clk while data is low must not start a frame.
        ps2_data = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        base = n_err;
        frame(8'h6B, 1'b0, 1'b0);
        expect_event("glitch_then_6b", {2'b00, 8'h6B});
        check_eq("glitch_no_err", n_err - base, 0);

        // Timeout: start bit + 4 data bits, then ps2_clk idles high.
        base = n_err;
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5);
        for (int i = 1; i <= int'(TIMEOUT) + int'(FILT) + 1; i++) begin
            @(posedge clk);
            #2;
            if (i == HALF) begin
                ps2_clk  = 1'b1;
                ps2_data = 1'b1;
            end
        end
        check_eq("tmo_strb_early", err_strb, 0);
        wait_cyc(1);
        check_eq("tmo_strb", err_strb, 1);
        check_eq("tmo_code", err_code, 2'b11);
        wait_cyc(GAP);
        check_eq("tmo_count", n_err - base, 1);
        frame(8'h5A, 1'b0, 1'b0);
        expect_event("ev_5a", {2'b00, 8'h5A});

        // Overflow: six events into a four-entry FIFO.
        evt_ready = 1'b0;
        base = n_ovf;
        for (int i = 0; i < 6; i++) frame(8'h1C, 1'b0, 1'b0);
        check_eq("ovf_count", n_ovf - base, 2);
        check_eq("ovf_valid", evt_valid, 1);
        evt_ready = 1'b1;
        wait_cyc(10);
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_event("drain_1c", {2'b00, 8'h1C});
        check_eq("drain_empty", ev_q.size(), 0);
        check_eq("drain_valid", evt_valid, 0);

        // Push and pop in the same edge while full.
        base = n_ovf;
        frame(8'h11, 1'b0, 1'b0);
        frame(8'h22, 1'b0, 1'b0);
        frame(8'h33, 1'b0, 1'b0);
        frame(8'h44, 1'b0, 1'b0);
        send_bits(mk_frame(8'h55, 1'b0, 1'b0), 11);
        wait_cyc(12);
        evt_ready = 1'b1;
        wait_cyc(1);
        evt_ready = 1'b0;
        end_frame();
        check_eq("full_pushpop_ovf", n_ovf - base, 0);
        expect_event("full_pop_11", {2'b00, 8'h11});
        evt_ready = 1'b1;
        wait_cyc(10);
        evt_ready = 1'b0;
        expect_event("full_22", {2'b00, 8'h22});
        expect_event("full_33", {2'b00, 8'h33});
        expect_event("full_44", {2'b00, 8'h44});
        expect_event("full_55", {2'b00, 8'h55});
        check_eq("full_empty", ev_q.size(), 0);

        // Reset mid-frame with an event held and err_code non-zero.
        frame(8'h3A, 1'b0, 1'b0);
        check_eq("pre_rst_valid", evt_valid, 1);
        send_bits(mk_frame(8'h99, 1'b0, 1'b0), 5);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(5);
        base = n_err;
        rst = 1'b1;
        wait_cyc(2);
        check_eq("mrst_valid", evt_valid, 0);
        check_eq("mrst_code", evt_code, 0);
        check_eq("mrst_err_code", err_code, 0);
        check_eq("mrst_err_strb", err_strb, 0);
        rst = 1'b0;
        wait_cyc(5);
        ps2_data = 1'b1;
        evt_ready = 1'b1;
        frame(8'h4B, 1'b0, 1'b0);
        expect_event("post_rst_4b", {2'b00, 8'h4B});
        check_eq("post_rst_no_err", n_err - base, 0);
        check_eq("post_rst_empty", ev_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
